// File: rtl/up_count_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// up_count_sequencer_pkg
//   Shared state encoding for the start/done up-count sequencer. Controller
//   FSMs that sequence this block use the same S_IDLE/S_RUN/S_DONE codes, so
//   the numeric values are fixed here and the enum is built from them.
//
//   Contents:
//     S_IDLE, S_RUN, S_DONE : 2-bit state codes (0, 1, 2)
//     state_t               : enum over those codes
//     limit_is_zero()       : helper used when choosing RUN vs DONE on entry
// -----------------------------------------------------------------------------
package up_count_sequencer_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_t;

  // A zero limit needs no ticks, so the sequence goes straight to DONE.
  function automatic logic limit_is_zero(input logic [31:0] lim);
    return (lim == 32'd0);
  endfunction

endpackage

// File: rtl/up_count_sequencer_up_counter.sv
// -----------------------------------------------------------------------------
// up_counter
//   Clearable up-counter with terminal compare against a latched limit.
//
//   Ports:
//     clk    in   1      rising-edge clock
//     rst    in   1      asynchronous active-high reset (count -> 0)
//     clear  in   1      synchronous clear to 0 (priority over en)
//     en     in   1      increment by one
//     limit  in   WIDTH  terminal value the count is compared against
//     count  out  WIDTH  registered count
//     last   out  1      1 when the next increment reaches limit
// -----------------------------------------------------------------------------
module up_counter
  import up_count_sequencer_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  // One extra bit so count+1 is exact even at count == 2^WIDTH-1.
  logic [WIDTH:0] count_inc;

  assign count_inc = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};
  assign last      = (count_inc == {1'b0, limit});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count_inc[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/up_count_sequencer.sv
// -----------------------------------------------------------------------------
// up_count_sequencer
//   Start/done sequenced up-counter. A start pulse latches limit and the block
//   counts en-qualified ticks from 0 up to that limit, showing busy while
//   counting and pulsing done for one cycle on arrival.
//
//   Build option: define AUTO_RELOAD_EN to make DONE reload the counter and
//   re-enter RUN with the same limit (periodic done, busy held through DONE).
//   Without it the block is one-shot.
//
//   Ports:
//     clk    in   1      rising-edge clock
//     rst    in   1      asynchronous active-high reset
//     start  in   1      request, honoured only in IDLE
//     limit  in   WIDTH  terminal count, sampled when start is accepted
//     en     in   1      tick qualifier in RUN
//     abort  in   1      cancel; returns to IDLE without done
//     count  out  WIDTH  current count (registered)
//     busy   out  1      counting
//     done   out  1      one cycle in DONE
// -----------------------------------------------------------------------------
module up_count_sequencer
  import up_count_sequencer_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

`ifdef AUTO_RELOAD_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif

  state_t           state;
  logic [WIDTH-1:0] limit_q;
  logic             accept;
  logic             reload;
  logic             cnt_clear;
  logic             cnt_en;
  logic             cnt_last;

  // abort beats start in IDLE and beats the reload in DONE.
  assign accept    = (state == ST_IDLE) && start && !abort;
  assign reload    = RELOAD && (state == ST_DONE) && !abort;
  assign cnt_clear = accept || reload;
  assign cnt_en    = (state == ST_RUN) && en && !abort;

  up_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .en    (cnt_en),
    .limit (limit_q),
    .count (count),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      limit_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            limit_q <= limit;
            state   <= limit_is_zero(32'(limit)) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (en && cnt_last) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // A zero limit under reload stays in DONE, giving done every cycle.
          if (reload) begin
            state <= limit_is_zero(32'(limit_q)) ? ST_DONE : ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Decoded from registered state only, so both are glitch-free.
  assign busy = (state == ST_RUN) || (RELOAD && (state == ST_DONE));
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_up_count_sequencer.sv
// -----------------------------------------------------------------------------
// tb_up_count_sequencer
//   Self-checking bench for up_count_sequencer (WIDTH=3). Fixed vector table,
//   hand-written multi-cycle sequences and a randomized run against a
//   behavioural model. Honours AUTO_RELOAD_EN when defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_up_count_sequencer;

  localparam int W = 3;
`ifdef AUTO_RELOAD_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] limit;
  logic         en;
  logic         abort;
  logic [W-1:0] count;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  // Behavioural model: how many ticks have been counted toward which target.
  int m_cnt;
  int m_lim;
  bit m_run;
  bit m_done;

  typedef struct {
    logic         s;
    logic [W-1:0] l;
    logic         e;
    logic         a;
    int           cnt;
    logic         b;
    logic         d;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  up_count_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .limit (limit),
    .en    (en),
    .abort (abort),
    .count (count),
    .busy  (busy),
    .done  (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_lim = 0; m_run = 0; m_done = 0;
  endtask

  task automatic model_step(input logic s, input int l, input logic e, input logic a);
    if (m_done) begin
      m_done = 0;
      if (RELOAD && !a) begin
        m_cnt = 0;
        if (m_lim == 0) m_done = 1;
        else            m_run  = 1;
      end
    end else if (m_run) begin
      if (a) begin
        m_run = 0;
      end else if (e) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == m_lim) begin
          m_run  = 0;
          m_done = 1;
        end
      end
    end else if (s && !a) begin
      m_lim = l;
      m_cnt = 0;
      if (m_lim == 0) m_done = 1;
      else            m_run  = 1;
    end
  endtask

  // Apply one cycle of inputs to model and DUT; returns 1ns after the edge.
  task automatic drive(input logic s, input logic [W-1:0] l, input logic e, input logic a);
    start = s; limit = l; en = e; abort = a;
    model_step(s, int'(l), e, a);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(m_cnt));
    chk({tag, "_busy"},  32'(busy),  32'(m_run || (RELOAD && m_done)));
    chk({tag, "_done"},  32'(done),  32'(m_done));
  endtask

  task automatic cyc(input string tag, input logic s, input logic [W-1:0] l,
                     input logic e, input logic a);
    drive(s, l, e, a);
    chk_model(tag);
  endtask

  function automatic vec_t mk(input logic s, input logic [W-1:0] l, input logic e,
                              input logic a, input int c, input logic b, input logic d);
    vec_t v;
    v.s = s; v.l = l; v.e = e; v.a = a; v.cnt = c; v.b = b; v.d = d;
    return v;
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; limit = '0; en = 1'b0; abort = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", 32'(count), 0);
    chk("reset_busy",  32'(busy),  0);
    chk("reset_done",  32'(done),  0);
    rst = 1'b0;

`ifndef AUTO_RELOAD_EN
    // limit=5 with en held: busy next cycle, count 1..5, one done, then hold.
    tbl.push_back(mk(1, 3'd5, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 3'd0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 3'd0, 1, 0, 2, 1, 0));
    tbl.push_back(mk(0, 3'd0, 1, 0, 3, 1, 0));
    tbl.push_back(mk(0, 3'd0, 1, 0, 4, 1, 0));
    tbl.push_back(mk(0, 3'd0, 1, 0, 5, 0, 1));
    tbl.push_back(mk(0, 3'd0, 1, 0, 5, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0, 0, 5, 0, 0));
    // limit=0: done next cycle, never busy, count cleared to 0.
    tbl.push_back(mk(1, 3'd0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0));
    // start together with abort is dropped.
    tbl.push_back(mk(1, 3'd3, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 3'd3, 1, 0, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].s, tbl[i].l, tbl[i].e, tbl[i].a);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_busy", i),  32'(busy),  32'(tbl[i].b));
      chk($sformatf("tbl%0d_done", i),  32'(done),  32'(tbl[i].d));
    end
`endif

    // en alternating: count moves only on en cycles, done on the 5th tick.
    cyc("alt_start", 1, 3'd5, 0, 0);
    for (int i = 0; i < 9; i++) begin
      cyc($sformatf("alt%0d", i), 0, 3'd5, (i % 2 == 0), 0);
    end
    chk("alt_final_done",  32'(done),  1);
    chk("alt_final_count", 32'(count), 5);
    cyc("alt_after", 0, 3'd0, 0, 1);

    // Abort at count 3; start and limit changes during RUN are ignored.
    cyc("ab_start", 1, 3'd6, 0, 0);
    for (int i = 0; i < 3; i++) cyc($sformatf("ab_tick%0d", i), 0, 3'd6, 1, 0);
    cyc("ab_restart", 1, 3'd7, 0, 0);
    chk("ab_still_busy", 32'(busy), 1);
    cyc("ab_limchg", 0, 3'd2, 0, 0);
    cyc("ab_abort", 0, 3'd2, 1, 1);
    chk("ab_count_held", 32'(count), 3);
    chk("ab_no_busy",    32'(busy),  0);
    chk("ab_no_done",    32'(done),  0);
    cyc("ab_idle", 0, 3'd2, 1, 0);

    // Limit latched: a smaller live limit must not end the run early.
    cyc("latch_start", 1, 3'd4, 0, 0);
    for (int i = 0; i < 5; i++) cyc($sformatf("latch%0d", i), 0, 3'd2, 1, 0);
    cyc("latch_stop", 0, 3'd0, 0, 1);

    // Asynchronous reset mid-run at count 2.
    cyc("ar_start", 1, 3'd6, 1, 0);
    cyc("ar_t0", 0, 3'd6, 1, 0);
    cyc("ar_t1", 0, 3'd6, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_busy",  32'(busy),  0);
    chk("ar_done",  32'(done),  0);
    model_reset();
    #2;
    rst = 1'b0;
    cyc("ar_restart", 1, 3'd3, 1, 0);
    for (int i = 0; i < 3; i++) cyc($sformatf("ar_run%0d", i), 0, 3'd3, 1, 0);
    chk("ar_done_after", 32'(done), 1);
    cyc("ar_stop", 0, 3'd0, 0, 1);

    // Full range limit: count reaches 7 without wrapping.
    cyc("fr_start", 1, 3'd7, 1, 0);
    for (int i = 0; i < 7; i++) cyc($sformatf("fr%0d", i), 0, 3'd7, 1, 0);
    chk("fr_count7", 32'(count), 7);
    chk("fr_done",   32'(done),  1);
    cyc("fr_after", 0, 3'd0, 0, 1);

`ifdef AUTO_RELOAD_EN
    // Periodic done every third cycle with limit=2, busy held, then abort.
    cyc("rl_start", 1, 3'd2, 1, 0);
    for (int i = 0; i < 9; i++) begin
      cyc($sformatf("rl%0d", i), 0, 3'd2, 1, 0);
      chk($sformatf("rl%0d_busy_const", i), 32'(busy), 1);
      chk($sformatf("rl%0d_period", i), 32'(done), 32'(i % 3 == 1));
    end
    cyc("rl_abort", 0, 3'd2, 1, 1);
    chk("rl_abort_busy", 32'(busy), 0);
    for (int i = 0; i < 4; i++) cyc($sformatf("rl_idle%0d", i), 0, 3'd2, 1, 0);
    // Zero limit under reload: done every cycle until abort.
    cyc("rl0_start", 1, 3'd0, 1, 0);
    for (int i = 0; i < 3; i++) cyc($sformatf("rl0_%0d", i), 0, 3'd0, 1, 0);
    chk("rl0_done", 32'(done), 1);
    cyc("rl0_abort", 0, 3'd0, 0, 1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc($sformatf("rnd%0d", i),
          ($urandom % 4) == 0,
          W'($urandom),
          ($urandom % 4) != 0,
          ($urandom % 16) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
